// File: rtl/ita_package.sv
// ita_package: ITA control, controller-step and scheduler job descriptor types
package ita_package;
  typedef enum logic [1:0] {Attention, Feedforward, Linear} layer_e;
  typedef enum logic [1:0] {Identity, Relu, Gelu} activation_e;
  typedef enum logic [3:0] {Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul} step_e;
  typedef struct packed {
    logic start;
    layer_e layer;
    activation_e activation;
    logic [7:0] eps_mult;
    logic [4:0] right_shift;
    logic [7:0] add;
    logic [11:0] tile_s;
  } ctrl_t;
  localparam int unsigned JobIdW = 4;
  typedef struct packed {
    ctrl_t ctrl;
    logic [JobIdW-1:0] id;
  } job_t;
endpackage

// File: rtl/ita_job_fifo.sv
// ita_job_fifo: power-of-two job queue with wrap-bit full/empty detection
module ita_job_fifo #(
  parameter int unsigned Depth = 4,
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(Depth);
  T mem [Depth];
  logic [AW:0] wptr_q, rptr_q;
  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign rdata = mem[rptr_q[AW-1:0]];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/ita_job_scheduler.sv
// ita_job_scheduler: round-robin job intake, queueing and ITA launch/complete sequencing
module ita_job_scheduler
  import ita_package::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned IdW = 4,
  localparam int unsigned ReqW = NumReq > 1 ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  input  job_t [NumReq-1:0] req_job_i,
  output logic              start_o,
  output ctrl_t             ctrl_o,
  input  step_e             step_i,
  input  logic              ita_busy_i,
  output logic              done_valid_o,
  input  logic              done_ready_i,
  output logic [IdW-1:0]    done_id_o,
  output logic [ReqW-1:0]   done_req_o,
  output logic              idle_o
);
  typedef struct packed {
    job_t job;
    logic [ReqW-1:0] req;
  } entry_t;
  typedef enum logic [2:0] {StIdle, StLaunch, StWaitStart, StRun, StComplete} state_e;
  state_e state_q, state_d;
  entry_t push_data, head, cur_q;
  logic full, empty, push, pop, gnt_vld;
  logic [ReqW-1:0] ptr_q, gnt_idx, idx;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = ReqW'((int'(ptr_q) + i) % int'(NumReq));
      if (!gnt_vld && req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  // ready is gated by reset so nothing looks accepted while rst_ni is low
  assign push = gnt_vld && !full && rst_ni;
  assign push_data = '{job: req_job_i[gnt_idx], req: gnt_idx};
  always_comb begin
    req_ready_o = '0;
    req_ready_o[gnt_idx] = push;
  end
  ita_job_fifo #(.Depth(QueueDepth), .T(entry_t)) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    case (state_q)
      StIdle: begin
        pop = !empty;
        state_d = empty ? StIdle : StLaunch;
      end
      StLaunch:    state_d = StWaitStart;
      StWaitStart: state_d = step_i != Idle ? StRun : StWaitStart;
      StRun:       state_d = (step_i == Idle && !ita_busy_i) ? StComplete : StRun;
      StComplete:  state_d = done_ready_i ? StIdle : StComplete;
      default:     state_d = StIdle;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q <= '0;
      cur_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) ptr_q <= (gnt_idx == ReqW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
      if (pop) cur_q <= head;
    end
  end
  assign start_o = state_q == StLaunch;
  always_comb begin
    ctrl_o = cur_q.job.ctrl;
    ctrl_o.start = start_o;
  end
  assign done_valid_o = state_q == StComplete;
  assign done_id_o = IdW'(cur_q.job.id);
  assign done_req_o = cur_q.req;
  assign idle_o = empty && state_q == StIdle;
endmodule
